// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state codes, timer width and filter depth.
package ps2_pkg;

  localparam int unsigned TIMER_W = 17;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned FILT_N  = 8;
  localparam int unsigned FILT_CW = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] ST_INHIBIT = 4'd1;
  localparam logic [STATE_W-1:0] ST_WAIT    = 4'd2;
  localparam logic [STATE_W-1:0] ST_DATA    = 4'd3;
  localparam logic [STATE_W-1:0] ST_PARITY  = 4'd4;
  localparam logic [STATE_W-1:0] ST_STOP    = 4'd5;
  localparam logic [STATE_W-1:0] ST_ACKW    = 4'd6;
  localparam logic [STATE_W-1:0] ST_DONE    = 4'd7;
  localparam logic [STATE_W-1:0] ST_FAIL    = 4'd8;

  // PS/2 frames carry odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser plus debounce for one PS/2 line; emits the filtered
// level and a one-ce pulse when that level falls.
module ps2_filter
  import ps2_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic raw,
  output logic level,
  output logic sync,
  output logic fall
);

  logic               meta;
  logic [FILT_CW-1:0] cnt;

  // Level flips only after FILT_N consecutive ce samples disagree with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else if (ce) begin
      meta <= raw;
      sync <= meta;
      fall <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == FILT_CW'(FILT_N - 1)) begin
        level <= sync;
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + FILT_CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, sends start/data/parity/stop
// on device clock falls, checks the ack and reports done or error per byte.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CE_MHZ     = 6,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned START_MS   = 15,
  parameter int unsigned XFER_MS    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2Ck,
  input  logic       ps2Dt,
  output logic       ckOe,
  output logic       dtOe,
  input  logic       txStrb,
  input  logic [7:0] txData,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INH_CNT   = INHIBIT_US * CE_MHZ;
  localparam int unsigned START_CNT = START_MS * CE_MHZ * 1000;
  localparam int unsigned XFER_CNT  = XFER_MS * CE_MHZ * 1000;

  logic ck_level, ck_sync, ck_fall;
  logic dt_level, dt_sync, dt_fall;
  logic filt_unused;

  ps2_filter u_ck_filt (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .raw   (ps2Ck),
    .level (ck_level),
    .sync  (ck_sync),
    .fall  (ck_fall)
  );

  ps2_filter u_dt_filt (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .raw   (ps2Dt),
    .level (dt_level),
    .sync  (dt_sync),
    .fall  (dt_fall)
  );

  assign filt_unused = ^{ck_sync, dt_level, dt_fall};

  logic [STATE_W-1:0] state, state_nx;
  logic [TIMER_W-1:0] timer, timer_nx;
  logic [8:0]         shreg, shreg_nx;
  logic [3:0]         bitcnt, bitcnt_nx;
  logic               ck_oe_nx, dt_oe_nx, busy_nx, done_nx, error_nx;
  logic               xfer_to;

  assign xfer_to = (timer == TIMER_W'(XFER_CNT - 1));

  // State and registered line/status outputs; reset ignores ce.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      timer  <= '0;
      shreg  <= '0;
      bitcnt <= '0;
      ckOe   <= 1'b0;
      dtOe   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else if (ce) begin
      state  <= state_nx;
      timer  <= timer_nx;
      shreg  <= shreg_nx;
      bitcnt <= bitcnt_nx;
      ckOe   <= ck_oe_nx;
      dtOe   <= dt_oe_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      error  <= error_nx;
    end
  end

  // Next-state and next-output logic; shreg[0] is always the next bit to drive.
  always_comb begin
    state_nx  = state;
    timer_nx  = (timer == '1) ? timer : timer + TIMER_W'(1);
    shreg_nx  = shreg;
    bitcnt_nx = bitcnt;
    ck_oe_nx  = ckOe;
    dt_oe_nx  = dtOe;
    busy_nx   = busy;
    done_nx   = 1'b0;
    error_nx  = 1'b0;

    case (state)
      ST_IDLE: begin
        timer_nx = '0;
        if (txStrb) begin
          shreg_nx = {odd_parity(txData), txData};
          ck_oe_nx = 1'b1;
          busy_nx  = 1'b1;
          state_nx = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (timer == TIMER_W'(INH_CNT - 1)) begin
          dt_oe_nx = 1'b1;
          ck_oe_nx = 1'b0;
          timer_nx = '0;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ck_fall) begin
          dt_oe_nx  = ~shreg[0];
          shreg_nx  = {1'b0, shreg[8:1]};
          bitcnt_nx = 4'd1;
          timer_nx  = '0;
          state_nx  = ST_DATA;
        end else if (timer == TIMER_W'(START_CNT - 1)) begin
          state_nx = ST_FAIL;
        end
      end
      ST_DATA: begin
        if (xfer_to) begin
          state_nx = ST_FAIL;
        end else if (ck_fall) begin
          dt_oe_nx = ~shreg[0];
          shreg_nx = {1'b0, shreg[8:1]};
          if (bitcnt == 4'd8) begin
            state_nx = ST_PARITY;
          end else begin
            bitcnt_nx = bitcnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (xfer_to) begin
          state_nx = ST_FAIL;
        end else if (ck_fall) begin
          dt_oe_nx = 1'b0;
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (xfer_to) begin
          state_nx = ST_FAIL;
        end else if (ck_fall) begin
          state_nx = dt_sync ? ST_FAIL : ST_ACKW;
        end
      end
      ST_ACKW: begin
        if (xfer_to) begin
          state_nx = ST_FAIL;
        end else if (ck_level && dt_sync) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_FAIL: state_nx = ST_IDLE;
      default: begin
        ck_oe_nx = 1'b0;
        dt_oe_nx = 1'b0;
        busy_nx  = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase

    // Entering FAIL releases both lines and flags the error for one ce.
    if (state_nx == ST_FAIL && state != ST_FAIL) begin
      ck_oe_nx = 1'b0;
      dt_oe_nx = 1'b0;
      busy_nx  = 1'b0;
      error_nx = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: behavioural PS/2 device on open-drain lines,
// table-driven and random byte sends, plus timeout, no-ack, reset and busy cases.
module tb_ps2_tx;

  localparam int unsigned CE_MHZ     = 6;
  localparam int unsigned INHIBIT_US = 120;
  localparam int unsigned START_MS   = 1;
  localparam int unsigned XFER_MS    = 2;
  localparam int INH_CNT   = INHIBIT_US * CE_MHZ;
  localparam int START_CNT = START_MS * CE_MHZ * 1000;
  localparam int H         = 30;

  localparam int M_OK     = 0;
  localparam int M_NOACK  = 1;
  localparam int M_ABORT  = 2;
  localparam int M_GLITCH = 3;

  logic       clock, reset, ce;
  logic       ckOe, dtOe, txStrb, busy, done, error;
  logic [7:0] txData;
  logic       dev_ck, dev_dt;
  wire        ck_line = dev_ck & ~ckOe;
  wire        dt_line = dev_dt & ~dtOe;

  int total = 0;
  int bad   = 0;
  int n_ckoe = 0, n_dtoe = 0, n_done = 0, n_err = 0, n_startbad = 0;

  ps2_tx #(
    .CE_MHZ     (CE_MHZ),
    .INHIBIT_US (INHIBIT_US),
    .START_MS   (START_MS),
    .XFER_MS    (XFER_MS)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .ps2Ck  (ck_line),
    .ps2Dt  (dt_line),
    .ckOe   (ckOe),
    .dtOe   (dtOe),
    .txStrb (txStrb),
    .txData (txData),
    .busy   (busy),
    .done   (done),
    .error  (error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clock);
      ce = ~ce;
    end
  end

  task automatic tick();
    do @(posedge clock); while (!ce);
    #1;
  endtask

  // Per-ce activity counters for the line enables and status pulses.
  initial begin
    logic prev_ck;
    prev_ck = 1'b0;
    forever begin
      tick();
      if (ckOe)  n_ckoe++;
      if (dtOe)  n_dtoe++;
      if (done)  n_done++;
      if (error) n_err++;
      if (prev_ck && !ckOe && !dtOe && !reset) n_startbad++;
      prev_ck = ckOe;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Device side: waits for start condition, clocks 11 pulses, samples on rising edges.
  task automatic device_xfer(input int mode, output logic [7:0] rx,
                             output logic rx_par, output logic rx_stop);
    int w;
    w = 0;
    rx = '0; rx_par = 1'b0; rx_stop = 1'b0;
    while (!(ck_line && !dt_line) && w < 3000) begin
      tick();
      w++;
    end
    if (w >= 3000) return;
    repeat (10) tick();
    for (int p = 1; p <= 11; p++) begin
      dev_ck = 1'b0;
      repeat (H) tick();
      if (p <= 8) rx[p-1] = dt_line;
      else if (p == 9) rx_par = dt_line;
      else if (p == 10) rx_stop = dt_line;
      dev_ck = 1'b1;
      if (p == 11) dev_dt = 1'b1;
      if (mode == M_ABORT && p == 5) begin
        repeat (15) tick();
        return;
      end
      if (mode == M_GLITCH && p == 4) begin
        repeat (12) tick();
        dev_ck = 1'b0;
        repeat (5) tick();
        dev_ck = 1'b1;
        repeat (H - 17) tick();
      end else if (p == 10 && mode != M_NOACK) begin
        repeat (5) tick();
        dev_dt = 1'b0;
        repeat (H - 5) tick();
      end else begin
        repeat (H) tick();
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input int mode, input bit exp_ok,
                      input bit extra_strobe, input string tag);
    int c0, d0, e0, s0, w;
    logic [7:0] rx;
    logic rp, rs, busy_end;
    @(negedge clock);
    c0 = n_ckoe; d0 = n_done; e0 = n_err; s0 = n_startbad;
    txData = d;
    txStrb = 1'b1;
    tick();
    txStrb = 1'b0;
    chk({tag, ".busy_rise"}, int'(busy), 1);
    busy_end = 1'b1;
    fork
      device_xfer(mode, rx, rp, rs);
      begin
        w = 0;
        while (!done && !error && w < 4000) begin
          tick();
          w++;
        end
        busy_end = busy;
      end
      if (extra_strobe) begin
        repeat (900) tick();
        txData = 8'hAA;
        txStrb = 1'b1;
        tick();
        txStrb = 1'b0;
      end
    join
    repeat (50) tick();
    @(negedge clock);
    chk({tag, ".inhibit_ce"}, n_ckoe - c0, INH_CNT);
    chk({tag, ".done_cnt"}, n_done - d0, exp_ok ? 1 : 0);
    chk({tag, ".err_cnt"}, n_err - e0, exp_ok ? 0 : 1);
    chk({tag, ".rx_byte"}, int'(rx), int'(d));
    chk({tag, ".rx_parity"}, int'(rp), ($countones(d) % 2 == 0) ? 1 : 0);
    chk({tag, ".rx_stop"}, int'(rs), 1);
    chk({tag, ".busy_at_end"}, int'(busy_end), 0);
    chk({tag, ".lines_idle"}, int'({ckOe, dtOe, busy}), 0);
    chk({tag, ".start_bit"}, n_startbad - s0, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    int         mode;
    bit         ok;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c0, d0, e0, t0, w;
    logic [7:0] rx;
    logic rp, rs;

    vecs[0] = '{8'hED, M_OK,     1'b1};
    vecs[1] = '{8'h01, M_OK,     1'b1};
    vecs[2] = '{8'hFF, M_OK,     1'b1};
    vecs[3] = '{8'h5A, M_NOACK,  1'b0};
    vecs[4] = '{8'h3C, M_GLITCH, 1'b1};

    reset = 1'b1; txStrb = 1'b0; txData = 8'h00; dev_ck = 1'b1; dev_dt = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("reset.ckOe",  int'(ckOe), 0);
    chk("reset.dtOe",  int'(dtOe), 0);
    chk("reset.busy",  int'(busy), 0);
    chk("reset.done",  int'(done), 0);
    chk("reset.error", int'(error), 0);

    // Reset must beat a strobe presented on the same ce.
    txData = 8'h12;
    txStrb = 1'b1;
    tick();
    txStrb = 1'b0;
    chk("reset_vs_strobe.busy", int'(busy), 0);
    reset = 1'b0;
    repeat (20) tick();

    for (int i = 0; i < 5; i++)
      send(vecs[i].data, vecs[i].mode, vecs[i].ok, 1'b0, $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++)
      send(8'($urandom_range(0, 255)), M_OK, 1'b1, 1'b0, $sformatf("rnd%0d", i));

    // Device never clocks: WAIT times out.
    @(negedge clock);
    c0 = n_ckoe; d0 = n_done; e0 = n_err; t0 = n_dtoe;
    txData = 8'h55;
    txStrb = 1'b1;
    tick();
    txStrb = 1'b0;
    w = 0;
    while (!error && w < INH_CNT + START_CNT + 200) begin
      tick();
      w++;
    end
    chk("timeout.error_seen", int'(error), 1);
    chk("timeout.busy", int'(busy), 0);
    repeat (5) tick();
    @(negedge clock);
    chk("timeout.inhibit_ce", n_ckoe - c0, INH_CNT);
    chk("timeout.wait_ce", n_dtoe - t0, START_CNT);
    chk("timeout.err_cnt", n_err - e0, 1);
    chk("timeout.done_cnt", n_done - d0, 0);
    chk("timeout.lines", int'({ckOe, dtOe}), 0);

    // Reset while bit 4 (a zero) is on the line.
    @(negedge clock);
    d0 = n_done; e0 = n_err;
    txData = 8'h0F;
    txStrb = 1'b1;
    tick();
    txStrb = 1'b0;
    device_xfer(M_ABORT, rx, rp, rs);
    chk("midreset.pre_busy", int'(busy), 1);
    chk("midreset.pre_dtOe", int'(dtOe), 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midreset.ckOe", int'(ckOe), 0);
    chk("midreset.dtOe", int'(dtOe), 0);
    chk("midreset.busy", int'(busy), 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (20) tick();
    @(negedge clock);
    chk("midreset.no_pulses", (n_done - d0) + (n_err - e0), 0);
    send(8'hF4, M_OK, 1'b1, 1'b0, "after_reset");

    // Strobe of 0xAA during a busy transfer must be ignored.
    send(8'h96, M_OK, 1'b1, 1'b1, "busy_strobe");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
